// File: rtl/cache_nway.sv
// N-way set-associative, write-through, write-no-allocate cache with round-robin replacement.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module cache_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              miss,
  output logic              ram_req,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_RD,
    S_MEM_WR,
    S_FLUSH
  } state_t;

  state_t state_q, state_d;

  logic              req_wr_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic              hit_q;
  logic [WAY_W-1:0]  victim_q;
  logic              victim_rr_q;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [DATA_W-1:0] hit_data;
  logic [WAY_W-1:0]  victim_way;
  logic              victim_rr;
  logic              resp_fire;
  logic              resp_miss;

  assign req_idx  = req_addr_q[IDX_W-1:0];
  assign req_tag  = req_addr_q[ADDR_W-1:IDX_W];
  assign hit_data = data_q[req_idx][hit_way];
  assign ready    = (state_q == S_IDLE);

  // Parallel tag compare plus victim choice: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_way = rr_q[req_idx];
    victim_rr  = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        victim_way = WAY_W'(w);
        victim_rr  = 1'b0;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    resp_fire = ((state_q == S_LOOKUP) && !req_wr_q && hit) ||
                (((state_q == S_MEM_RD) || (state_q == S_MEM_WR)) && ram_ack);
    resp_miss = (state_q == S_MEM_RD) || ((state_q == S_MEM_WR) && !hit_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (flush)    state_d = S_FLUSH;
        else if (req) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (req_wr_q) state_d = S_MEM_WR;
        else if (hit) state_d = S_IDLE;
        else          state_d = S_MEM_RD;
      end
      S_MEM_RD: if (ram_ack) state_d = S_IDLE;
      S_MEM_WR: if (ram_ack) state_d = S_IDLE;
      S_FLUSH:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      hit_q       <= 1'b0;
      victim_q    <= '0;
      victim_rr_q <= 1'b0;
      resp_valid  <= 1'b0;
      rdata       <= '0;
      miss        <= 1'b0;
      ram_req     <= 1'b0;
      ram_wr      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      resp_valid <= resp_fire;
      if (resp_fire) miss <= resp_miss;
      case (state_q)
        S_IDLE: begin
          if (req && !flush) begin
            req_wr_q    <= wr;
            req_addr_q  <= addr;
            req_wdata_q <= wdata;
          end
        end
        S_LOOKUP: begin
          hit_q       <= hit;
          victim_q    <= victim_way;
          victim_rr_q <= victim_rr;
          if (req_wr_q || !hit) begin
            ram_req   <= 1'b1;
            ram_wr    <= req_wr_q;
            ram_addr  <= req_addr_q;
            ram_wdata <= req_wdata_q;
          end else begin
            rdata <= hit_data;
          end
        end
        S_MEM_RD: begin
          if (ram_ack) begin
            ram_req                    <= 1'b0;
            rdata                      <= ram_rdata;
            valid_q[req_idx][victim_q] <= 1'b1;
            if (victim_rr_q) rr_q[req_idx] <= rr_q[req_idx] + WAY_W'(1);
          end
        end
        S_MEM_WR: begin
          if (ram_ack) ram_req <= 1'b0;
        end
        S_FLUSH: begin
          for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage needs no reset: valid bits gate every use of tag and data.
  always_ff @(posedge clk) begin
    if ((state_q == S_LOOKUP) && req_wr_q && hit) begin
      data_q[req_idx][hit_way] <= req_wdata_q;
    end
    if ((state_q == S_MEM_RD) && ram_ack) begin
      data_q[req_idx][victim_q] <= ram_rdata;
      tag_q[req_idx][victim_q]  <= req_tag;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == S_FLUSH) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (resp_fire) begin
      if (resp_miss) miss_count <= miss_count + 32'd1;
      else           hit_count  <= hit_count + 32'd1;
    end
  end
`endif

endmodule
